// File: rtl/cndm_proto_desc_rd_if.sv
// Bus interfaces for the RX descriptor reader: AXI-Stream descriptor output,
// DMA descriptor request/status channels and the DMA RAM write port.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [7:0]          tid;
    logic [7:0]          tdest;
    logic [USER_W-1:0]   tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

interface taxi_dma_desc_if;
    logic [63:0] req_src_addr;
    logic [63:0] req_dst_addr;
    logic [19:0] req_len;
    logic [7:0]  req_tag;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  sts_error;
    logic        sts_valid;

    modport req_src (output req_src_addr, req_dst_addr, req_len, req_tag, req_valid, input req_ready);
    modport req_snk (input req_src_addr, req_dst_addr, req_len, req_tag, req_valid, output req_ready);
    modport sts_src (output sts_error, sts_valid);
    modport sts_snk (input sts_error, sts_valid);
endinterface

interface taxi_dma_ram_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W/8-1:0] wr_cmd_be;
    logic [7:0]          wr_cmd_addr;
    logic [DATA_W-1:0]   wr_cmd_data;
    logic                wr_cmd_valid;
    logic                wr_cmd_ready;
    logic                wr_done;

    modport wr_slv (input wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid, output wr_cmd_ready, wr_done);
    modport wr_mst (output wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid, input wr_cmd_ready, wr_done);
endinterface

// File: rtl/cndm_proto_desc_rd.sv
// RX descriptor reader: fetches one 16-byte ring descriptor per request via host DMA.
// Optional WAIT timeout enabled by defining CNDM_DESC_RD_TIMEOUT_EN.
module cndm_proto_desc_rd #(
    parameter int DESC_W = 128,
    parameter int PTR_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    desc_req,
    taxi_axis_if.src                axis_desc,
    taxi_dma_desc_if.req_src        dma_rd_desc_req,
    taxi_dma_desc_if.sts_snk        dma_rd_desc_sts,
    taxi_dma_ram_if.wr_slv          dma_ram_wr,
    input  logic                    cfg_enable,
    input  logic [63:0]             cfg_base_addr,
    input  logic [3:0]              cfg_log_size,
    input  logic [PTR_W-1:0]        prod_ptr,
    output logic [PTR_W-1:0]        cons_ptr
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUTPUT = 2'd3} state_t;

    state_t              state, state_n;
    logic                pending, pending_n, pend_clr;
    logic [PTR_W-1:0]    cons_n;
    logic [DESC_W-1:0]   out_data, out_data_n, desc_buf;
    logic                out_user, out_user_n;
    logic                out_valid, out_valid_n;
    logic                req_valid, req_valid_n;
    logic [63:0]         req_addr, req_addr_n;
    logic                ram_done;
    logic [1:0]          rst_sync;
    logic                rst_int_n;
    logic [PTR_W-1:0]    ring_mask;
    logic [63:0]         ring_off;
`ifdef CNDM_DESC_RD_TIMEOUT_EN
    logic [15:0]         tmo_cnt, tmo_cnt_n;
`endif

    // Assertion is immediate; release takes effect after two clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign ring_mask = ~({PTR_W{1'b1}} << cfg_log_size);
    assign ring_off  = 64'(cons_ptr & ring_mask) << 4;

    always_comb begin
        state_n     = state;
        pend_clr    = 1'b0;
        cons_n      = cons_ptr;
        out_data_n  = out_data;
        out_user_n  = out_user;
        out_valid_n = out_valid;
        req_valid_n = req_valid;
        req_addr_n  = req_addr;
`ifdef CNDM_DESC_RD_TIMEOUT_EN
        tmo_cnt_n   = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (pending) begin
                    pend_clr = 1'b1;
                    if (!cfg_enable || prod_ptr == cons_ptr) begin
                        out_valid_n = 1'b1;
                        out_user_n  = 1'b1;
                        out_data_n  = '0;
                        state_n     = OUTPUT;
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Address is latched on the first ISSUE cycle and held with req_valid.
                if (!req_valid) begin
                    req_valid_n = 1'b1;
                    req_addr_n  = cfg_base_addr + ring_off;
                end else if (dma_rd_desc_req.req_ready) begin
                    req_valid_n = 1'b0;
                    state_n     = WAIT;
`ifdef CNDM_DESC_RD_TIMEOUT_EN
                    tmo_cnt_n   = '0;
`endif
                end
            end
            WAIT: begin
                if (dma_rd_desc_sts.sts_valid) begin
                    out_data_n  = desc_buf;
                    out_valid_n = 1'b1;
                    out_user_n  = |dma_rd_desc_sts.sts_error;
                    if (dma_rd_desc_sts.sts_error == '0) cons_n = cons_ptr + 1'b1;
                    state_n     = OUTPUT;
                end
`ifdef CNDM_DESC_RD_TIMEOUT_EN
                else if (tmo_cnt == 16'hFFFF) begin
                    out_data_n  = '0;
                    out_valid_n = 1'b1;
                    out_user_n  = 1'b1;
                    state_n     = OUTPUT;
                end else begin
                    tmo_cnt_n = tmo_cnt + 16'd1;
                end
`endif
            end
            OUTPUT: begin
                if (axis_desc.tready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        pending_n = pending ? !pend_clr : desc_req;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            cons_ptr  <= '0;
            out_data  <= '0;
            out_user  <= 1'b0;
            out_valid <= 1'b0;
            req_valid <= 1'b0;
            req_addr  <= '0;
`ifdef CNDM_DESC_RD_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            cons_ptr  <= cons_n;
            out_data  <= out_data_n;
            out_user  <= out_user_n;
            out_valid <= out_valid_n;
            req_valid <= req_valid_n;
            req_addr  <= req_addr_n;
`ifdef CNDM_DESC_RD_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_n;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            desc_buf <= '0;
            ram_done <= 1'b0;
        end else begin
            ram_done <= dma_ram_wr.wr_cmd_valid;
            if (dma_ram_wr.wr_cmd_valid && dma_ram_wr.wr_cmd_addr == '0) begin
                for (int unsigned i = 0; i < DESC_W / 8; i++) begin
                    if (dma_ram_wr.wr_cmd_be[i]) desc_buf[i*8 +: 8] <= dma_ram_wr.wr_cmd_data[i*8 +: 8];
                end
            end
        end
    end

    assign dma_ram_wr.wr_cmd_ready = rst_int_n;
    assign dma_ram_wr.wr_done      = ram_done;

    assign dma_rd_desc_req.req_src_addr = req_addr;
    assign dma_rd_desc_req.req_dst_addr = '0;
    assign dma_rd_desc_req.req_len      = 20'd16;
    assign dma_rd_desc_req.req_tag      = '0;
    assign dma_rd_desc_req.req_valid    = req_valid;

    assign axis_desc.tdata  = out_data;
    assign axis_desc.tkeep  = '0;
    assign axis_desc.tvalid = out_valid;
    assign axis_desc.tlast  = 1'b1;
    assign axis_desc.tid    = '0;
    assign axis_desc.tdest  = '0;
    assign axis_desc.tuser  = out_user;
endmodule

// File: doc/cndm_proto_desc_rd.md
CNDM_PROTO_DESC_RD -- requirements
Module: cndm_proto_desc_rd

Interface
REQ-001 Parameter DESC_W, default 128: descriptor width in bits (16 bytes).
REQ-002 Parameter PTR_W, default 16: producer/consumer pointer width.
REQ-003 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port desc_req, input, 1: single-cycle request for one RX descriptor.
REQ-006 Port axis_desc, taxi_axis_if.src, DATA_W=DESC_W, USER_W=1: descriptor out; tuser=1 means no descriptor delivered.
REQ-007 Port dma_rd_desc_req, taxi_dma_desc_if.req_src: host DMA read request.
REQ-008 Port dma_rd_desc_sts, taxi_dma_desc_if.sts_snk: host DMA read status.
REQ-009 Port dma_ram_wr, taxi_dma_ram_if.wr_slv: DMA engine's write port into the block's 16-byte descriptor buffer.
REQ-010 Ports cfg_enable (1), cfg_base_addr (64), cfg_log_size (4), input: ring enable, byte base address, log2 entry count.
REQ-011 Port prod_ptr, input, PTR_W: host-written producer index.
REQ-012 Port cons_ptr, output, PTR_W: consumer index, registered.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, OUTPUT; any other encoding -> IDLE next cycle.
REQ-014 desc_req sampled high in any state sets a one-deep pending flag; further requests while pending are dropped (the RX datapath issues only one outstanding request).
REQ-015 IDLE with pending: clear pending; if !cfg_enable or prod_ptr==cons_ptr, drive axis_desc tvalid=1, tuser=1, tdata=0 and go OUTPUT; else go ISSUE.
REQ-016 ISSUE: req_src_addr = cfg_base_addr + ((cons_ptr & ((1<<cfg_log_size)-1)) << 4), 64-bit wrap; req_dst_addr=0, req_len=16, req_tag=0, other req fields 0; req_valid=1, held until req_ready; then WAIT.
REQ-017 dma_ram_wr: each write enable with segment address 0 captures byte lanes per byte enable into the 128-bit buffer; wr_done asserted one cycle after each accepted write; wr_cmd_ready held 1 outside reset.
REQ-018 WAIT: on sts_valid, tdata = buffer; sts_error==0 -> tuser=0 and cons_ptr += 1 (mod 2^PTR_W); sts_error!=0 -> tuser=1, cons_ptr unchanged; tvalid=1; go OUTPUT.
REQ-019 OUTPUT: hold tdata/tuser/tvalid stable until tvalid && tready, then tvalid=0, go IDLE; tlast=1, tkeep/tid/tdest tied 0.
REQ-020 Pointer comparison uses full PTR_W bits; wrap of cons_ptr from 2^PTR_W-1 to 0 is normal operation.
REQ-021 Latency: desc_req high at edge k -> empty/disabled response tvalid high after edge k+1; non-empty -> req_valid high after edge k+2.
REQ-022 cfg_* and prod_ptr changes take effect only at the IDLE decision; in-flight reads complete with the values latched at ISSUE.

Reset
REQ-023 rst_n low asynchronously forces: state IDLE, pending 0, cons_ptr 0, buffer 0, axis_desc tvalid 0, req_valid 0, wr_done 0.
REQ-024 Reset mid-WAIT abandons the read; a later sts_valid in IDLE is ignored; release is synchronized so the first active edge follows two clk edges after rst_n rises.

Configuration
REQ-025 Macro CNDM_DESC_RD_TIMEOUT_EN defined: 16-bit counter cleared on WAIT entry, increments each WAIT cycle; reaching 0xFFFF emits tuser=1, cons_ptr unchanged, go OUTPUT, and a late sts_valid is ignored.
REQ-026 Macro undefined: no counter; WAIT exits only on sts_valid.

Verification
REQ-027 cfg_enable=1, prod=0, cons=0, desc_req -> axis_desc tuser=1, tdata=0, no DMA request, cons_ptr stays 0.
REQ-028 base=0x1000_0000, log_size=4, prod=3, cons=0x0011 -> req_src_addr=0x1000_0010, len=16; ram write 0xA5.. with sts_error=0 -> tdata=0xA5.., tuser=0, cons_ptr=0x0012.
REQ-029 sts_error=1 -> tuser=1, cons_ptr unchanged; tready held low 10 cycles -> tdata/tuser stable throughout.
REQ-030 cons=0xFFFF, prod=0x0000, log_size=2 -> addr offset 0x30; success -> cons_ptr=0x0000.
REQ-031 rst_n low during WAIT, then sts_valid after release -> no axis_desc output, cons_ptr=0.
REQ-032 With CNDM_DESC_RD_TIMEOUT_EN, no sts_valid -> tuser=1 after 65535 WAIT cycles; without macro, no output after 100000 cycles.
